// File: rtl/display_pkg.sv
// Shared BCD definitions for the 7-segment display path.
package display_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  function automatic logic is_valid_bcd(input logic [BCD_W-1:0] code);
    return code <= BCD_MAX;
  endfunction

endpackage

// File: rtl/display_scan_tick_gen.sv
// Free-running prescaler: oTick is high on the last cycle of every DIV-cycle period.
module tick_gen #(
  parameter int DIV = 50000
) (
  input  logic iClk,
  input  logic iRst,
  output logic oTick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] prescaler;

  assign oTick = (prescaler == LAST);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      prescaler <= '0;
    end else if (oTick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + CNT_W'(1);
    end
  end

endmodule

// File: rtl/display_scan.sv
// Multiplexed 7-segment scan driver; the shadow BCD word only changes at frame
// boundaries so a scan never mixes digits from two different values.
module display_scan
  import display_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iLoad,
  input  logic [BCD_W*DIGITS-1:0] iBcd,
  input  logic                    iBlankLz,
  output logic [BCD_W-1:0]        oDigit,
  output logic [DIGITS-1:0]       oAnode,
  output logic                    oFrame
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic                    tick;
  logic [IDX_W-1:0]        idx;
  logic [BCD_W*DIGITS-1:0] shadow;
  logic [BCD_W*DIGITS-1:0] pending;
  logic                    pendValid;
  logic                    frameEnd;
  logic [DIGITS-1:0]       blank;
  logic [BCD_W-1:0]        code;
  logic                    lead;

  tick_gen #(.DIV(DIV)) uTick (
    .iClk  (iClk),
    .iRst  (iRst),
    .oTick (tick)
  );

  assign frameEnd = tick && (idx == LAST_IDX);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    end
  end

  // A load landing on the boundary goes straight to the shadow and leaves nothing pending.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      shadow    <= '0;
      pending   <= '0;
      pendValid <= 1'b0;
    end else if (frameEnd) begin
      if (iLoad) begin
        shadow <= iBcd;
      end else if (pendValid) begin
        shadow <= pending;
      end
      pendValid <= 1'b0;
    end else if (iLoad) begin
      pending   <= iBcd;
      pendValid <= 1'b1;
    end
  end

  // Walk from the most significant digit down; an invalid digit above still counts as "dark".
  always_comb begin
    lead  = 1'b1;
    code  = '0;
    blank = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      code     = shadow[k*BCD_W +: BCD_W];
      blank[k] = !is_valid_bcd(code) || (iBlankLz && (k != 0) && (code == '0) && lead);
      lead     = lead && ((code == '0) || blank[k]);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oDigit <= '0;
      oAnode <= '1;
      oFrame <= 1'b0;
    end else begin
      oDigit <= shadow[idx*BCD_W +: BCD_W];
      oAnode <= blank[idx] ? '1 : ~(DIGITS'(1) << idx);
      oFrame <= frameEnd;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: directed scenarios then random traffic, checked cycle by cycle
// against a counter-based model of the scan timing and shadow/pending behaviour.
module tb_display_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int FRAME  = DIV * DIGITS;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iLoad = 1'b0;
  logic [15:0] iBcd = '0;
  logic        iBlankLz = 1'b0;
  logic [3:0]  oDigit;
  logic [3:0]  oAnode;
  logic        oFrame;

  display_scan #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iLoad    (iLoad),
    .iBcd     (iBcd),
    .iBlankLz (iBlankLz),
    .oDigit   (oDigit),
    .oAnode   (oAnode),
    .oFrame   (oFrame)
  );

  always #5 iClk = ~iClk;

  int          e = 0;
  logic [15:0] mShadow = '0;
  logic [15:0] mPend = '0;
  bit          mHas = 1'b0;
  int          nPass = 0;
  int          nTotal = 0;

  // Digit k is dark if its code is invalid, or (when blanking) it sits above the
  // highest valid non-zero digit; digit 0 always shows.
  function automatic bit isBlank(input logic [15:0] s, input int k, input logic blz);
    int          lead;
    logic [3:0]  nib;
    lead = -1;
    for (int j = 0; j < DIGITS; j++) begin
      nib = s[4*j +: 4];
      if (nib != 0 && nib <= 9) lead = j;
    end
    nib = s[4*k +: 4];
    if (nib > 9) return 1'b1;
    return blz && (k > 0) && (k > lead);
  endfunction

  task automatic cycle(input logic rst, input logic load, input logic [15:0] bcd, input logic blz);
    logic [3:0] expDigit;
    logic [3:0] expAnode;
    logic       expFrame;
    int         slot;
    iRst = rst;
    iLoad = load;
    iBcd = bcd;
    iBlankLz = blz;
    @(posedge iClk);
    if (rst) begin
      expDigit = 4'h0;
      expAnode = 4'hF;
      expFrame = 1'b0;
      mShadow = '0;
      mPend = '0;
      mHas = 1'b0;
      e = 0;
    end else begin
      slot = (e / DIV) % DIGITS;
      expDigit = mShadow[4*slot +: 4];
      expAnode = isBlank(mShadow, slot, blz) ? 4'hF : ~(4'b0001 << slot);
      expFrame = ((e % FRAME) == FRAME - 1);
      if (expFrame) begin
        if (load) mShadow = bcd;
        else if (mHas) mShadow = mPend;
        mHas = 1'b0;
      end else if (load) begin
        mPend = bcd;
        mHas = 1'b1;
      end
      e++;
    end
    #1;
    nTotal++;
    assert (oAnode === expAnode) nPass++;
    else $error("FAIL anode t=%0t got %b expected %b", $time, oAnode, expAnode);
    nTotal++;
    assert (oFrame === expFrame) nPass++;
    else $error("FAIL frame t=%0t got %b expected %b", $time, oFrame, expFrame);
    nTotal++;
    assert (oDigit === expDigit) nPass++;
    else $error("FAIL digit t=%0t got %h expected %h", $time, oDigit, expDigit);
  endtask

  task automatic idle(input int n, input logic blz);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, blz);
  endtask

  // Advance (at most one frame) until the next edge has the requested frame phase.
  task automatic idleUntil(input int phase, input logic blz);
    for (int i = 0; i < FRAME; i++) begin
      if ((e % FRAME) == phase) break;
      cycle(1'b0, 1'b0, 16'h0, blz);
    end
  endtask

  logic [15:0] rndBcd;

  initial begin
    // reset, then an all-zero display with leading-zero blanking
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    cycle(1'b1, 1'b1, 16'h9999, 1'b1);
    idle(40, 1'b1);

    // plain value, no blanking
    idleUntil(3, 1'b0);
    cycle(1'b0, 1'b1, 16'h1234, 1'b0);
    idle(40, 1'b0);

    // leading zeros, with and without blanking
    cycle(1'b0, 1'b1, 16'h0050, 1'b1);
    idle(36, 1'b1);
    idle(32, 1'b0);

    // invalid code in digit 1
    cycle(1'b0, 1'b1, 16'h12A4, 1'b0);
    idle(36, 1'b0);

    // two loads in one frame: only the second ever reaches the display
    idleUntil(5, 1'b0);
    cycle(1'b0, 1'b1, 16'h1111, 1'b0);
    idle(2, 1'b0);
    cycle(1'b0, 1'b1, 16'h2222, 1'b0);
    idle(40, 1'b0);

    // load coinciding with the frame boundary
    idleUntil(FRAME - 1, 1'b0);
    cycle(1'b0, 1'b1, 16'h8765, 1'b0);
    idle(20, 1'b0);

    // reset in the middle of slot 2
    idleUntil(2 * DIV + 1, 1'b0);
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    idle(20, 1'b0);

    // random traffic
    for (int i = 0; i < 900; i++) begin
      for (int d = 0; d < DIGITS; d++) begin
        rndBcd[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 11));
      end
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), rndBcd,
            1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
